rgy_monitor: RTL and testbench

- Receiving end of the traffic-light output interface. Watches the green/yellow/red lines produced by the light controller, one sample per clock tick (one tick = 5 s).
- Reconstructs the current phase and locks onto the G->Y->R->G sequence.
- Checks each phase duration against the programmed timing and raises sticky fault flags. It also counts clean full cycles.
- Sits beside the controller as a safety/diagnostic checker and feeds the fault logger.

---
 rtl/rgy_pkg.sv | 22 ++
 rtl/rgy_monitor_if.sv | 19 +
 rtl/rgy_phase_timer.sv | 24 ++
 rtl/rgy_monitor.sv | 96 +++++++++
 tb/tb_rgy_monitor.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rgy_pkg.sv
// rgy_pkg: phase encoding, default timing, next-phase rule and error bit indices
package rgy_pkg;
  localparam logic [1:0] PH_UNK = 2'd0;
  localparam logic [1:0] PH_G   = 2'd1;
  localparam logic [1:0] PH_Y   = 2'd2;
  localparam logic [1:0] PH_R   = 2'd3;
  localparam int GT_DEF = 15;
  localparam int YT_DEF = 1;
  localparam int RT_DEF = 17;
  localparam int ERR_PATTERN = 0;
  localparam int ERR_ORDER   = 1;
  localparam int ERR_SHORT   = 2;
  localparam int ERR_LONG    = 3;
  localparam int ERR_W       = 4;
  typedef enum logic {ST_ACQ, ST_TRACK} state_e;
  function automatic logic [1:0] next_ph(input logic [1:0] p);
    return p == PH_G ? PH_Y : p == PH_Y ? PH_R : p == PH_R ? PH_G : PH_UNK;
  endfunction
  function automatic logic [1:0] lamp_ph(input logic [2:0] s);
    return s == 3'b100 ? PH_G : s == 3'b010 ? PH_Y : s == 3'b001 ? PH_R : PH_UNK;
  endfunction
endpackage

// File: rtl/rgy_monitor_if.sv
// rgy_monitor_if: lamp lines from the controller plus the monitor's status/fault outputs
interface rgy_monitor_if #(parameter int CYC_W = 16);
  logic             green;
  logic             yellow;
  logic             red;
  logic             clear_err;
  logic [1:0]       phase;
  logic             locked;
  logic             err_pattern;
  logic             err_order;
  logic             err_short;
  logic             err_long;
  logic             err_pulse;
  logic [CYC_W-1:0] cycle_count;
  modport master (output green, yellow, red, clear_err,
                  input phase, locked, err_pattern, err_order, err_short, err_long, err_pulse, cycle_count);
  modport slave  (input green, yellow, red, clear_err,
                  output phase, locked, err_pattern, err_order, err_short, err_long, err_pulse, cycle_count);
endinterface

// File: rtl/rgy_phase_timer.sv
// rgy_phase_timer: saturating phase-duration counter with short/long compares
module rgy_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             advance,
  input  logic [CNT_W-1:0] exp_len,
  output logic [CNT_W-1:0] dur_cnt,
  output logic             short_flag,
  output logic             long_hit
);
  logic [CNT_W-1:0] cnt_q, cnt_d, inc;
  assign inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign cnt_d = restart ? CNT_W'(1) : advance ? inc : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign dur_cnt = cnt_q;
  assign short_flag = cnt_q < exp_len;
  // a saturated counter never re-hits, so long fires once per phase entry
  assign long_hit = ~&cnt_q && ({1'b0, inc} == {1'b0, exp_len} + 1'b1);
endmodule

// File: rtl/rgy_monitor.sv
// rgy_monitor: tracks G->Y->R lamp sequence, checks phase durations, counts clean cycles
module rgy_monitor import rgy_pkg::*; #(
  parameter int GT    = GT_DEF,
  parameter int YT    = YT_DEF,
  parameter int RT    = RT_DEF,
  parameter int CNT_W = 6,
  parameter int CYC_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  rgy_monitor_if.slave  bus
);
  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d, prev_q, prev_d, s_ph;
  logic             locked_q, locked_d, full_seen_q, full_seen_d, cycle_err_q, cycle_err_d;
  logic             pulse_q, restart, advance, rg, cyc_err_now;
  logic [ERR_W-1:0] err_q, err_d, ev;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] exp_len, dur_cnt;
  logic             short_flag, long_hit;
  assign s_ph = lamp_ph({bus.green, bus.yellow, bus.red});
  assign exp_len = phase_q == PH_G ? CNT_W'(GT) : phase_q == PH_Y ? CNT_W'(YT) : CNT_W'(RT);
  rgy_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk, .rst(reset), .restart, .advance, .exp_len, .dur_cnt, .short_flag, .long_hit
  );
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    prev_d = prev_q;
    locked_d = locked_q;
    restart = 1'b0;
    advance = 1'b0;
    rg = 1'b0;
    ev = '0;
    if (state_q == ST_ACQ) begin
      if (s_ph == PH_UNK) ev[ERR_PATTERN] = 1'b1;
      else if (prev_q != PH_UNK && s_ph == next_ph(prev_q)) begin
        state_d = ST_TRACK;
        restart = 1'b1;
        locked_d = 1'b1;
        phase_d = s_ph;
      end else prev_d = s_ph;
    end else if (s_ph == phase_q) begin
      advance = 1'b1;
      ev[ERR_LONG] = long_hit;
    end else if (s_ph == next_ph(phase_q)) begin
      ev[ERR_SHORT] = short_flag;
      restart = 1'b1;
      phase_d = s_ph;
      rg = phase_q == PH_R;
    end else begin
      ev[ERR_ORDER] = s_ph != PH_UNK;
      ev[ERR_PATTERN] = s_ph == PH_UNK;
      state_d = ST_ACQ;
      locked_d = 1'b0;
      phase_d = PH_UNK;
      prev_d = s_ph;
    end
  end
  // errors raised on the closing R->G edge still spoil that cycle
  assign cyc_err_now = cycle_err_q | (|ev & locked_q);
  assign cycle_err_d = rg ? 1'b0 : cyc_err_now;
  assign full_seen_d = rg | (full_seen_q & state_d == ST_TRACK);
  assign cycle_d = rg && full_seen_q && !cyc_err_now && !(&cycle_q) ? cycle_q + 1'b1 : cycle_q;
  assign err_d = ev | (err_q & {ERR_W{~bus.clear_err}});
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ST_ACQ;
      phase_q <= PH_UNK;
      prev_q <= PH_UNK;
      locked_q <= 1'b0;
      full_seen_q <= 1'b0;
      cycle_err_q <= 1'b0;
      err_q <= '0;
      pulse_q <= 1'b0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      prev_q <= prev_d;
      locked_q <= locked_d;
      full_seen_q <= full_seen_d;
      cycle_err_q <= cycle_err_d;
      err_q <= err_d;
      pulse_q <= |ev;
      cycle_q <= cycle_d;
    end
  assign bus.phase = phase_q;
  assign bus.locked = locked_q;
  assign bus.err_pattern = err_q[ERR_PATTERN];
  assign bus.err_order = err_q[ERR_ORDER];
  assign bus.err_short = err_q[ERR_SHORT];
  assign bus.err_long = err_q[ERR_LONG];
  assign bus.err_pulse = pulse_q;
  assign bus.cycle_count = cycle_q;
endmodule

// File: tb/tb_rgy_monitor.sv
// tb_rgy_monitor: directed scenarios for the traffic-light sequence monitor
module tb_rgy_monitor;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rgy_monitor_if #(.CYC_W(16)) bus ();
  rgy_monitor #(.GT(15), .YT(1), .RT(17), .CNT_W(6), .CYC_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  task automatic step(input logic g, input logic y, input logic r, input logic c);
    bus.green = g;
    bus.yellow = y;
    bus.red = r;
    bus.clear_err = c;
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    checks++;
    if ({bus.phase, bus.locked, bus.err_pattern, bus.err_order, bus.err_short, bus.err_long, bus.err_pulse} !== 7'd0 || bus.cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL %s: phase=%0d locked=%b errs=%b%b%b%b pulse=%b count=%0d, required all 0", tag, bus.phase, bus.locked,
               bus.err_pattern, bus.err_order, bus.err_short, bus.err_long, bus.err_pulse, bus.cycle_count);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    check_zero("reset");
  endtask
  task automatic test_nominal;
    for (int i = 1; i <= 100; i++) begin
      int p = (i - 1) % 33;
      step(p < 15, p == 15, p > 15, 0);
      checks++;
      if ({bus.err_pattern, bus.err_order, bus.err_short, bus.err_long, bus.err_pulse} !== 5'd0) begin
        errors++;
        $display("FAIL nominal_err sample %0d: errs=%b%b%b%b pulse=%b, required 0", i, bus.err_pattern, bus.err_order, bus.err_short, bus.err_long, bus.err_pulse);
      end
      if (i == 15) begin
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL nominal_unlocked15: locked=%b, required 0", bus.locked); end
      end
      if (i == 16) begin
        checks++;
        if (bus.locked !== 1'b1 || bus.phase !== 2'd2) begin errors++; $display("FAIL nominal_lock16: locked=%b phase=%0d, required 1/2", bus.locked, bus.phase); end
      end
      if (i == 17) begin
        checks++;
        if (bus.phase !== 2'd3) begin errors++; $display("FAIL nominal_phase17: phase=%0d, required 3", bus.phase); end
      end
      if (i == 34) begin
        checks++;
        if (bus.phase !== 2'd1) begin errors++; $display("FAIL nominal_phase34: phase=%0d, required 1", bus.phase); end
      end
      if (i == 66 || i == 67 || i == 100) begin
        int exp_c = i == 66 ? 0 : i == 67 ? 1 : 2;
        checks++;
        if (bus.cycle_count !== 16'(exp_c)) begin errors++; $display("FAIL nominal_count%0d: count=%0d, required %0d", i, bus.cycle_count, exp_c); end
      end
    end
  endtask
  task automatic test_long_yellow;
    repeat (14) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (bus.err_long !== 1'b0) begin errors++; $display("FAIL ly_first_y: err_long=%b, required 0", bus.err_long); end
    step(0, 1, 0, 0);
    checks++;
    if (bus.err_long !== 1'b1 || bus.err_pulse !== 1'b1) begin errors++; $display("FAIL ly_second_y: err_long=%b pulse=%b, required 1/1", bus.err_long, bus.err_pulse); end
    step(0, 0, 1, 0);
    checks++;
    if (bus.err_short !== 1'b0 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL ly_red: err_short=%b pulse=%b, required 0/0", bus.err_short, bus.err_pulse); end
    repeat (16) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    checks++;
    if (bus.cycle_count !== 16'd2 || bus.phase !== 2'd1) begin errors++; $display("FAIL ly_no_count: count=%0d phase=%0d, required 2/1", bus.cycle_count, bus.phase); end
    step(1, 0, 0, 1);
    checks++;
    if (bus.err_long !== 1'b0) begin errors++; $display("FAIL ly_clear: err_long=%b, required 0", bus.err_long); end
  endtask
  task automatic test_short_green;
    repeat (8) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (bus.err_short !== 1'b1 || bus.err_pulse !== 1'b1 || bus.phase !== 2'd2 || bus.err_long !== 1'b0) begin
      errors++;
      $display("FAIL sg_short: err_short=%b pulse=%b phase=%0d err_long=%b, required 1/1/2/0", bus.err_short, bus.err_pulse, bus.phase, bus.err_long);
    end
    step(0, 0, 1, 1);
    checks++;
    if (bus.err_short !== 1'b0 || bus.err_pulse !== 1'b0 || bus.phase !== 2'd3) begin
      errors++;
      $display("FAIL sg_clear: err_short=%b pulse=%b phase=%0d, required 0/0/3", bus.err_short, bus.err_pulse, bus.phase);
    end
  endtask
  task automatic test_order_pattern;
    repeat (16) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    checks++;
    if (bus.phase !== 2'd1 || bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.cycle_count !== 16'd2) begin
      errors++;
      $display("FAIL op_green: phase=%0d locked=%b pulse=%b count=%0d, required 1/1/0/2", bus.phase, bus.locked, bus.err_pulse, bus.cycle_count);
    end
    step(0, 0, 1, 0);
    checks++;
    if (bus.err_order !== 1'b1 || bus.locked !== 1'b0 || bus.phase !== 2'd0 || bus.err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL op_order: err_order=%b locked=%b phase=%0d pulse=%b, required 1/0/0/1", bus.err_order, bus.locked, bus.phase, bus.err_pulse);
    end
    step(1, 1, 0, 0);
    checks++;
    if (bus.err_pattern !== 1'b1 || bus.err_pulse !== 1'b1 || bus.err_order !== 1'b1) begin
      errors++;
      $display("FAIL op_two_lamps: err_pattern=%b pulse=%b err_order=%b, required 1/1/1", bus.err_pattern, bus.err_pulse, bus.err_order);
    end
    step(0, 0, 0, 0);
    checks++;
    if (bus.err_pattern !== 1'b1 || bus.err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL op_dark: err_pattern=%b pulse=%b, required 1/1", bus.err_pattern, bus.err_pulse);
    end
  endtask
  task automatic test_reset_mid;
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    check_zero("reset_after_errors");
    for (int i = 1; i <= 86; i++) begin
      int p = (i - 1) % 33;
      step(p < 15, p == 15, p > 15, 0);
      if (i == 67) begin
        checks++;
        if (bus.cycle_count !== 16'd1) begin errors++; $display("FAIL rm_count67: count=%0d, required 1", bus.cycle_count); end
      end
    end
    checks++;
    if (bus.phase !== 2'd3 || bus.locked !== 1'b1) begin errors++; $display("FAIL rm_mid_red: phase=%0d locked=%b, required 3/1", bus.phase, bus.locked); end
    reset = 1'b1;
    step(0, 0, 1, 0);
    reset = 1'b0;
    check_zero("reset_mid_red");
    for (int i = 1; i <= 16; i++) begin
      step(i < 16, i == 16, 0, 0);
      if (i == 15) begin
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL rm_reacq15: locked=%b, required 0", bus.locked); end
      end
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.phase !== 2'd2 || bus.err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rm_reacq16: locked=%b phase=%0d pulse=%b, required 1/2/0", bus.locked, bus.phase, bus.err_pulse);
    end
  endtask
  task automatic test_clear_same_edge;
    repeat (17) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    checks++;
    if (bus.err_pulse !== 1'b0 || bus.phase !== 2'd1) begin errors++; $display("FAIL cs_green: pulse=%b phase=%0d, required 0/1", bus.err_pulse, bus.phase); end
    repeat (14) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    checks++;
    if (bus.err_long !== 1'b1 || bus.err_pulse !== 1'b1) begin errors++; $display("FAIL cs_set_wins: err_long=%b pulse=%b, required 1/1", bus.err_long, bus.err_pulse); end
    step(0, 1, 0, 1);
    checks++;
    if (bus.err_long !== 1'b0 || bus.err_short !== 1'b0 || bus.err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL cs_cleared: err_long=%b err_short=%b pulse=%b, required 0/0/0", bus.err_long, bus.err_short, bus.err_pulse);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.green = 1'b0;
    bus.yellow = 1'b0;
    bus.red = 1'b0;
    bus.clear_err = 1'b0;
    test_reset;
    test_nominal;
    test_long_yellow;
    test_short_green;
    test_order_pattern;
    test_reset_mid;
    test_clear_same_edge;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
